// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register file with combinational read
// ports, write-through bypass from the write-back port, and a per-register
// busy scoreboard that tracks writes still outstanding in the pipeline.
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS),
    localparam int CW      = $clog2(NREGS + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rbusy,
    input  logic                we3,
    input  logic [AW-1:0]       wa3,
    input  logic [XLEN-1:0]     wd3,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ok,
    output logic [NREGS-1:0]    busy,
    output logic [CW-1:0]       pend_cnt
);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] busy_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             wr_ok;
    logic             set_ok;

    // Register 0 is never written nor marked busy when it is hardwired.
    assign wr_ok  = we3 && !(ZERO_REG != 0 && wa3 == '0);
    assign iss_ok = iss_en && (!busy[iss_rd] || (we3 && wa3 == iss_rd));
    assign set_ok = iss_ok && !(ZERO_REG != 0 && iss_rd == '0);

    // Read ports: zero register first, then same-cycle write-back bypass, then storage.
    always_comb begin
        rd    = '0;
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (ZERO_REG != 0 && ra[i*AW +: AW] == '0)
                rd[i*XLEN +: XLEN] = '0;
            else if (we3 && wa3 == ra[i*AW +: AW])
                rd[i*XLEN +: XLEN] = wd3;
            else
                rd[i*XLEN +: XLEN] = mem[ra[i*AW +: AW]];
            rbusy[i] = busy[ra[i*AW +: AW]] && !(we3 && wa3 == ra[i*AW +: AW]);
        end
    end

    // Next busy vector: write-back clears, accepted issue sets (set wins on a tie).
    always_comb begin
        busy_nxt = busy;
        if (we3)
            busy_nxt[wa3] = 1'b0;
        if (set_ok)
            busy_nxt[iss_rd] = 1'b1;
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++)
            cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
    end

    // Register storage update from the write-back port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                mem[i] <= '0;
        end else if (wr_ok) begin
            mem[wa3] <= wd3;
        end
    end

    // Scoreboard state; the count is registered from the same next-state vector
    // so it always equals the popcount of busy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard: directed scenarios plus randomized
// traffic checked against an array-based reference model.
module tb_regfile_scoreboard;
    localparam int XLEN = 32, NREGS = 32, NRD = 2, AW = 5, CW = 6;
    localparam int XB = 16, NB = 16, RB = 4, AWB = 4, CWB = 5;

    logic clock = 1'b0;
    logic reset = 1'b0;

    logic [NRD*AW-1:0]   ra = '0;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rbusy;
    logic                we3 = 1'b0;
    logic [AW-1:0]       wa3 = '0;
    logic [XLEN-1:0]     wd3 = '0;
    logic                iss_en = 1'b0;
    logic [AW-1:0]       iss_rd = '0;
    logic                iss_ok;
    logic [NREGS-1:0]    busy;
    logic [CW-1:0]       pend_cnt;

    logic [RB*AWB-1:0]   ra_b = '0;
    logic [RB*XB-1:0]    rd_b;
    logic [RB-1:0]       rbusy_b;
    logic                we3_b = 1'b0;
    logic [AWB-1:0]      wa3_b = '0;
    logic [XB-1:0]       wd3_b = '0;
    logic                iss_ok_b;
    logic [NB-1:0]       busy_b;
    logic [CWB-1:0]      pend_cnt_b;

    int errors = 0;
    int checks = 0;

    logic [XLEN-1:0] mem_m [NREGS];
    bit              busy_m [NREGS];

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)) u_dut (
        .clock(clock), .reset(reset), .ra(ra), .rd(rd), .rbusy(rbusy),
        .we3(we3), .wa3(wa3), .wd3(wd3), .iss_en(iss_en), .iss_rd(iss_rd),
        .iss_ok(iss_ok), .busy(busy), .pend_cnt(pend_cnt)
    );

    regfile_scoreboard #(.XLEN(XB), .NREGS(NB), .NRD(RB), .ZERO_REG(1)) u_dut_b (
        .clock(clock), .reset(reset), .ra(ra_b), .rd(rd_b), .rbusy(rbusy_b),
        .we3(we3_b), .wa3(wa3_b), .wd3(wd3_b), .iss_en(1'b0), .iss_rd(4'd0),
        .iss_ok(iss_ok_b), .busy(busy_b), .pend_cnt(pend_cnt_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] m_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (we3 && wa3 == a) return wd3;
        return mem_m[a];
    endfunction

    function automatic logic m_rbusy(input logic [AW-1:0] a);
        return busy_m[a] && !(we3 && wa3 == a);
    endfunction

    function automatic logic m_iss_ok();
        return iss_en && (!busy_m[iss_rd] || (we3 && wa3 == iss_rd));
    endfunction

    function automatic int m_pend();
        int n = 0;
        foreach (busy_m[i]) n += int'(busy_m[i]);
        return n;
    endfunction

    function automatic logic [NREGS-1:0] m_busy_vec();
        logic [NREGS-1:0] v;
        foreach (busy_m[i]) v[i] = busy_m[i];
        return v;
    endfunction

    task automatic model_clear();
        foreach (mem_m[i]) begin
            mem_m[i]  = '0;
            busy_m[i] = 1'b0;
        end
    endtask

    task automatic check_comb();
        logic [AW-1:0] a;
        for (int i = 0; i < NRD; i++) begin
            a = ra[i*AW +: AW];
            check($sformatf("rd%0d[r%0d]", i, a), rd[i*XLEN +: XLEN], m_rd(a));
            check($sformatf("rbusy%0d[r%0d]", i, a), rbusy[i], m_rbusy(a));
        end
        check("iss_ok", iss_ok, m_iss_ok());
    endtask

    // One clock: check combinational outputs, take the edge, update model, check state.
    task automatic cycle();
        bit ok;
        #1;
        check_comb();
        ok = m_iss_ok();
        @(posedge clock);
        if (reset) begin
            model_clear();
        end else begin
            if (we3 && wa3 != 0) mem_m[wa3] = wd3;
            if (we3) busy_m[wa3] = 1'b0;
            if (ok && iss_rd != 0) busy_m[iss_rd] = 1'b1;
        end
        #1;
        check("busy", busy, m_busy_vec());
        check("pend_cnt", pend_cnt, m_pend());
    endtask

    initial begin
        model_clear();
        @(negedge clock);

        // Reset and zero register
        reset = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_pend", pend_cnt, 0);
        cycle();
        reset = 1'b0;
        ra = {5'd5, 5'd0};
        we3 = 1'b1; wa3 = 5'd5; wd3 = 32'h12345678;
        cycle();
        wa3 = 5'd0; wd3 = 32'hDEADBEEF;
        cycle();
        we3 = 1'b0;
        #1;
        check("zero_r0", rd[31:0], 32'h0);
        check("zero_r5", rd[63:32], 32'h12345678);
        check_comb();

        // Write-through bypass
        ra = {5'd0, 5'd30};
        we3 = 1'b1; wa3 = 5'd30; wd3 = 32'h87654321;
        #1;
        check("byp_same", rd[31:0], 32'h87654321);
        cycle();
        check("byp_after", rd[31:0], 32'h87654321);
        wd3 = 32'h89654321;
        #1;
        check("byp_follow", rd[31:0], 32'h89654321);
        cycle();
        we3 = 1'b0;

        // Scoreboard WAW stall and set-wins
        iss_en = 1'b1; iss_rd = 5'd7;
        #1;
        check("iss_r7", iss_ok, 1);
        cycle();
        check("waw_stall", iss_ok, 0);
        check("busy7", busy[7], 1);
        check("pend1", pend_cnt, 1);
        cycle();
        we3 = 1'b1; wa3 = 5'd7; wd3 = 32'hA5A5A5A5;
        #1;
        check("wb_iss_ok", iss_ok, 1);
        cycle();
        check("busy7_kept", busy[7], 1);
        check("pend1_kept", pend_cnt, 1);
        we3 = 1'b0; iss_en = 1'b0;

        // Read status
        iss_en = 1'b1; iss_rd = 5'd3;
        cycle();
        iss_en = 1'b0;
        ra = {5'd3, 5'd7};
        #1;
        check("rbusy1_set", rbusy[1], 1);
        we3 = 1'b1; wa3 = 5'd3; wd3 = 32'h0BADF00D;
        #1;
        check("rbusy1_byp", rbusy[1], 0);
        check("rd1_byp", rd[63:32], 32'h0BADF00D);
        cycle();
        we3 = 1'b0;

        // Async reset between edges
        we3 = 1'b1; wa3 = 5'd9; wd3 = 32'h55;
        cycle();
        we3 = 1'b0; iss_en = 1'b1;
        iss_rd = 5'd1; cycle();
        iss_rd = 5'd2; cycle();
        iss_rd = 5'd9; cycle();
        iss_en = 1'b0;
        ra = {5'd2, 5'd9};
        #1;
        check("pre_rst_r9", rd[31:0], 32'h55);
        #1;
        reset = 1'b1;
        #1;
        model_clear();
        check("arst_busy", busy, 0);
        check("arst_pend", pend_cnt, 0);
        check("arst_rd_r9", rd[31:0], 0);
        check("arst_rbusy", rbusy, 0);
        reset = 1'b0;
        cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            ra     = NRD*AW'($urandom);
            we3    = 1'($urandom_range(0, 1));
            wa3    = AW'($urandom);
            wd3    = $urandom;
            iss_en = ($urandom_range(0, 9) < 7);
            iss_rd = AW'($urandom);
            cycle();
        end
        iss_en = 1'b0;

        // Sweep on the default instance
        for (int j = 0; j < NREGS; j++) begin
            we3 = 1'b1; wa3 = AW'(j); wd3 = 32'(j) * 32'h01010101;
            cycle();
        end
        we3 = 1'b0;
        for (int j = 0; j < NREGS; j++) begin
            ra = {AW'(NREGS - 1 - j), AW'(j)};
            #1;
            check($sformatf("sweep_r%0d", j), rd[31:0], (j == 0) ? 32'h0 : 32'(j) * 32'h01010101);
            check_comb();
        end

        // Sweep on the 16-bit, 16-register, 4-port instance
        for (int j = 0; j < NB; j++) begin
            we3_b = 1'b1; wa3_b = AWB'(j); wd3_b = 16'(j) * 16'h0101;
            @(posedge clock);
            #1;
        end
        we3_b = 1'b0;
        for (int g = 0; g < NB / RB; g++) begin
            for (int p = 0; p < RB; p++)
                ra_b[p*AWB +: AWB] = AWB'(g * RB + p);
            #1;
            for (int p = 0; p < RB; p++)
                check($sformatf("sweep16_r%0d", g * RB + p), rd_b[p*XB +: XB],
                      (g * RB + p == 0) ? 16'h0 : 16'(g * RB + p) * 16'h0101);
        end
        check("b_busy", busy_b, 0);
        check("b_pend", pend_cnt_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised successor to the lab0 integer register file: a configurable-width, configurable-depth register file with NRD combinational read ports, one write-back port with same-cycle write-through bypass, and a per-register busy scoreboard that tracks outstanding writes. It sits between decode/issue and write-back in the pipelined core. Issue stalls on WAW hazards, and operand reads return busy status alongside data.

## Interface
- XLEN, 32, data width in bits (8..64)
- NREGS, 32, number of architectural registers (power of 2, 2..64)
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, register 0 is hardwired to zero and never becomes busy
- AW (localparam), $clog2(NREGS), register address width
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all registers, busy bits and the counter
- ra  in  NRD*AW  packed read addresses; port i uses ra[i*AW +: AW]
- rd  out  NRD*XLEN  packed read data, combinational
- rbusy  out  NRD  busy flag per read port, combinational
- we3  in  1  write-back enable
- wa3  in  AW  write-back address
- wd3  in  XLEN  write-back data
- iss_en  in  1  issue request that claims a destination register
- iss_rd  in  AW  destination register of the issuing instruction
- iss_ok  out  1  issue accepted this cycle (combinational)
- busy  out  NREGS  registered busy vector
- pend_cnt  out  $clog2(NREGS+1)  number of set busy bits (registered)

## Operation
- Storage: NREGS x XLEN flops, all 0 after reset.
- Write: at the rising edge, when we3=1 and wa3 is not the zero register, mem[wa3] <= wd3. Writes to register 0 are dropped when ZERO_REG=1.
- Read port i: rd_i = 0 when ZERO_REG and ra_i==0.
  - Otherwise, wd3 when we3 and wa3==ra_i (write-through bypass).
  - Otherwise, mem[ra_i].
- rbusy_i = busy[ra_i] & ~(we3 & wa3==ra_i). A same-cycle write-back makes the operand valid through the bypass.
- iss_ok = iss_en & (~busy[iss_rd] | (we3 & wa3==iss_rd)). Issue to a busy destination stalls (WAW) unless that register is being written back this cycle.
- Busy update at the rising edge:
  - we3 clears busy[wa3].
  - iss_ok sets busy[iss_rd], except for register 0 when ZERO_REG=1.
  - If both events hit the same register, set wins: the new producer is outstanding.
- Issue to register 0 with ZERO_REG=1: iss_ok=iss_en, and nothing is set.
- Write-back to a non-busy register is legal. Data is written and the busy bit stays 0.
- pend_cnt is the registered popcount of busy. It must always equal the popcount of busy after each edge; it is never a free-running counter.
- Address inputs must be in range; NREGS is a power of 2, so there is no wrap-around case.

## Timing
- Read latency 0: rd and rbusy are combinational from ra, we3, wa3, wd3 and state.
- Write latency 1 edge to storage. Data is visible combinationally in the same cycle via the bypass.
- Busy set/clear takes effect on the edge after iss_ok/we3. busy and pend_cnt reflect it from that edge on.
- iss_ok depends combinationally on iss_en, iss_rd, we3, wa3 and busy. There is no path from rd to iss_ok.
- Reset is asserted asynchronously. Regardless of clock, all of the following go to 0 immediately: mem, busy, pend_cnt, and rd except for bypassed values, and rbusy.
- Reset mid-operation: in-flight issues are forgotten. The first edge after reset deasserts behaves as from power-up.

## Test plan
- Reset/zero: assert reset, then write 0x12345678 to r5 and 0xDEADBEEF to r0 with ra={0,5}. Required: rd={0x00000000,0x12345678}, and r0 stays 0.
- Bypass: we3=1, wa3=30, wd3=0x87654321, ra0=30, before the edge. Required: rd0=0x87654321 in the same cycle and after the edge; change wd3 to 0x89654321 before the next edge and rd0 follows.
- Scoreboard: issue r7 (iss_ok=1), then re-issue r7 the next cycle. Required: iss_ok=0, busy[7]=1, pend_cnt=1. Write back r7=0xA5A5A5A5 with a simultaneous issue of r7. Required: iss_ok=1, busy[7] stays 1, pend_cnt=1.
- Read status: busy[3]=1, ra1=3, we3=0 gives rbusy1=1. With we3=1 and wa3=3, rbusy1=0 and rd1=wd3.
- Async reset mid-op: busy={r1,r2,r9}, r9=0x55. Pulse reset between edges. Required: busy=0, pend_cnt=0 and rd(r9)=0 immediately, without waiting for an edge.
- Sweep: for j=0..31 write j*0x01010101 to rj, then read both ports. Required: r0=0 and rj=j*0x01010101. Repeat with XLEN=16, NREGS=16, NRD=4.
